// File: rtl/riscvdefs_pkg.sv
// Definitions shared between the multicycle control unit and the load/store unit:
// access length codes, LSU FSM encodings, bus payload type and lane helpers.
package riscvdefs;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    typedef enum logic [1:0] {
        LOAD_STORE_BYTE = 2'd0,
        LOAD_STORE_HALF = 2'd1,
        LOAD_STORE_WORD = 2'd2,
        LOAD_STORE_RSVD = 2'd3
    } ls_len_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [NBYTES-1:0] byte_en;
        logic [XLEN-1:0]   wdata;
    } lsu_bus_t;

    function automatic logic [NBYTES-1:0] lane_byte_en(input ls_len_e len, input logic [1:0] off);
        case (len)
            LOAD_STORE_BYTE: return 4'b0001 << off;
            LOAD_STORE_HALF: return 4'b0011 << {off[1], 1'b0};
            default:         return 4'hF;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input ls_len_e len, input logic [XLEN-1:0] wd);
        case (len)
            LOAD_STORE_BYTE: return {4{wd[7:0]}};
            LOAD_STORE_HALF: return {2{wd[15:0]}};
            default:         return wd;
        endcase
    endfunction

    // HALF needs off[0]==0, WORD (and the reserved code) needs off==0
    function automatic logic is_misaligned(input ls_len_e len, input logic [1:0] off);
        case (len)
            LOAD_STORE_BYTE: return 1'b0;
            LOAD_STORE_HALF: return off[0];
            default:         return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data lane extraction with zero/sign extension; shared
// by the uncached bus path and any later cached path.
module load_extract
    import riscvdefs::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  ls_len_e         i_len,
    input  logic            i_sign_ext,
    output logic [XLEN-1:0] o_result_c
);

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;

    // HALF honours only off[1]; WORD ignores the offset entirely
    always_comb begin
        w_shamt = 5'd0;
        case (i_len)
            LOAD_STORE_BYTE: w_shamt = {i_off, 3'b000};
            LOAD_STORE_HALF: w_shamt = {i_off[1], 4'b0000};
            default:         w_shamt = 5'd0;
        endcase
    end

    assign w_shifted = i_rdata >> w_shamt;

    always_comb begin
        o_result_c = w_shifted;
        case (i_len)
            LOAD_STORE_BYTE: o_result_c = {{24{i_sign_ext & w_shifted[7]}}, w_shifted[7:0]};
            LOAD_STORE_HALF: o_result_c = {{16{i_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
            default:         o_result_c = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns a control-unit request into a word-aligned bus
// transaction and returns extended load data. Optional: LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import riscvdefs::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [XLEN-1:0]       writeData,
    input  logic [1:0]            len,
    input  logic                  signExtend,
    output logic                  respValid,
    output logic [XLEN-1:0]       readData,
    output logic                  respError,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [NBYTES-1:0]     memByteEn,
    output logic [XLEN-1:0]       memWdata,
    input  logic                  memAck,
    input  logic [XLEN-1:0]       memRdata
);

    lsu_state_e            r_state,      w_state_nxt;
    logic                  r_req_ready,  w_req_ready_nxt;
    logic                  r_resp_valid, w_resp_valid_nxt;
    logic [XLEN-1:0]       r_read_data,  w_read_data_nxt;
    logic                  r_mem_req,    w_mem_req_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_nxt;
    lsu_bus_t              r_bus,        w_bus_nxt;
    logic [1:0]            r_off,        w_off_nxt;
    ls_len_e               r_len,        w_len_nxt;
    logic                  r_sext,       w_sext_nxt;
    logic                  r_write,      w_write_nxt;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  r_resp_error, w_resp_error_nxt;
`endif

    ls_len_e               w_req_len;
    logic [XLEN-1:0]       w_load_result;

    assign w_req_len = ls_len_e'(len);

    load_extract u_load_extract (
        .i_rdata    (memRdata),
        .i_off      (r_off),
        .i_len      (r_len),
        .i_sign_ext (r_sext),
        .o_result_c (w_load_result)
    );

    // State and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LSU_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_read_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_bus        <= '0;
            r_off        <= 2'b00;
            r_len        <= LOAD_STORE_BYTE;
            r_sext       <= 1'b0;
            r_write      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_resp_error <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_read_data  <= w_read_data_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_bus        <= w_bus_nxt;
            r_off        <= w_off_nxt;
            r_len        <= w_len_nxt;
            r_sext       <= w_sext_nxt;
            r_write      <= w_write_nxt;
`ifdef LSU_MISALIGN_TRAP_EN
            r_resp_error <= w_resp_error_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_req_ready_nxt  = r_req_ready;
        w_resp_valid_nxt = r_resp_valid;
        w_read_data_nxt  = r_read_data;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_bus_nxt        = r_bus;
        w_off_nxt        = r_off;
        w_len_nxt        = r_len;
        w_sext_nxt       = r_sext;
        w_write_nxt      = r_write;
`ifdef LSU_MISALIGN_TRAP_EN
        w_resp_error_nxt = r_resp_error;
`endif

        case (r_state)
            LSU_IDLE: begin
                if (reqValid) begin
                    w_off_nxt         = address[1:0];
                    w_len_nxt         = w_req_len;
                    w_sext_nxt        = signExtend;
                    w_write_nxt       = reqWrite;
                    w_mem_addr_nxt    = {address[ADDR_WIDTH-1:2], 2'b00};
                    w_bus_nxt.we      = reqWrite;
                    w_bus_nxt.byte_en = lane_byte_en(w_req_len, address[1:0]);
                    w_bus_nxt.wdata   = lane_wdata(w_req_len, writeData);
                    w_req_ready_nxt   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    w_resp_error_nxt  = 1'b0;
                    if (is_misaligned(w_req_len, address[1:0])) begin
                        // Trap: no bus cycle, respond with error and zero data
                        w_bus_nxt.we     = 1'b0;
                        w_read_data_nxt  = '0;
                        w_resp_error_nxt = 1'b1;
                        w_resp_valid_nxt = 1'b1;
                        w_state_nxt      = LSU_RESP;
                    end else begin
                        w_mem_req_nxt    = 1'b1;
                        w_state_nxt      = LSU_REQ;
                    end
`else
                    w_mem_req_nxt     = 1'b1;
                    w_state_nxt       = LSU_REQ;
`endif
                end
            end
            LSU_REQ: begin
                if (memAck) begin
                    if (!r_write) begin
                        w_read_data_nxt = w_load_result;
                    end
                    w_mem_req_nxt    = 1'b0;
                    w_bus_nxt.we     = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = LSU_RESP;
                end
            end
            LSU_RESP: begin
                w_resp_valid_nxt = 1'b0;
                w_req_ready_nxt  = 1'b1;
                w_state_nxt      = LSU_IDLE;
            end
            default: begin
                w_resp_valid_nxt = 1'b0;
                w_mem_req_nxt    = 1'b0;
                w_req_ready_nxt  = 1'b1;
                w_state_nxt      = LSU_IDLE;
            end
        endcase
    end

    assign reqReady  = r_req_ready;
    assign respValid = r_resp_valid;
    assign readData  = r_read_data;
    assign memReq    = r_mem_req;
    assign memWe     = r_bus.we;
    assign memAddr   = r_mem_addr;
    assign memByteEn = r_bus.byte_en;
    assign memWdata  = r_bus.wdata;
`ifdef LSU_MISALIGN_TRAP_EN
    assign respError = r_resp_error;
`else
    assign respError = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (default and LSU_MISALIGN_TRAP_EN builds).
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [1:0]  len;
    logic        signExtend;
    logic        respValid;
    logic [31:0] readData;
    logic        respError;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWrite   (reqWrite),
        .address    (address),
        .writeData  (writeData),
        .len        (len),
        .signExtend (signExtend),
        .respValid  (respValid),
        .readData   (readData),
        .respError  (respError),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memByteEn  (memByteEn),
        .memWdata   (memWdata),
        .memAck     (memAck),
        .memRdata   (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && reqReady !== 1'b1; i++) tick();
        check_eq({tag, " reqReady"}, 32'(reqReady), 32'd1);
    endtask

    // One access with memAck asserted 'dly' cycles after memReq first rises
    task automatic access(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] l, input logic sx,
                          input int dly, input logic [31:0] rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata);
        wait_ready(tag);
        reqValid = 1'b1; reqWrite = wr; address = a; writeData = wd; len = l; signExtend = sx;
        tick();
        reqValid = 1'b0; address = 32'hFFFF_FFFF; writeData = 32'h5555_5555;
        for (int i = 0; i <= dly; i++) begin
            check_eq({tag, " memReq"},    32'(memReq), 32'd1);
            check_eq({tag, " memAddr"},   memAddr, {a[31:2], 2'b00});
            check_eq({tag, " memByteEn"}, 32'(memByteEn), 32'(exp_be));
            check_eq({tag, " memWdata"},  memWdata, exp_wdata);
            check_eq({tag, " memWe"},     32'(memWe), 32'(wr));
            check_eq({tag, " respValid early"}, 32'(respValid), 32'd0);
            if (i == dly) begin
                memAck = 1'b1; memRdata = rd;
            end
            tick();
        end
        memAck = 1'b0; memRdata = 32'hDEAD_BEEF;
        check_eq({tag, " respValid"}, 32'(respValid), 32'd1);
        check_eq({tag, " memReq drop"}, 32'(memReq), 32'd0);
        check_eq({tag, " memWe drop"}, 32'(memWe), 32'd0);
        check_eq({tag, " readData"},  readData, exp_rdata);
        check_eq({tag, " respError"}, 32'(respError), 32'd0);
        tick();
        check_eq({tag, " respValid pulse"}, 32'(respValid), 32'd0);
        check_eq({tag, " reqReady back"}, 32'(reqReady), 32'd1);
        check_eq({tag, " readData held"}, readData, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; address = '0; writeData = '0;
        len = 2'd0; signExtend = 1'b0; memAck = 1'b0; memRdata = '0;
        tick(); tick();
        check_eq("rst reqReady",  32'(reqReady), 32'd1);
        check_eq("rst respValid", 32'(respValid), 32'd0);
        check_eq("rst respError", 32'(respError), 32'd0);
        check_eq("rst readData",  readData, 32'd0);
        check_eq("rst memReq",    32'(memReq), 32'd0);
        check_eq("rst memWe",     32'(memWe), 32'd0);
        check_eq("rst memAddr",   memAddr, 32'd0);
        check_eq("rst memByteEn", 32'(memByteEn), 32'd0);
        check_eq("rst memWdata",  memWdata, 32'd0);
        reset = 1'b0;
        tick();

        // memAck outside REQ has no effect
        memAck = 1'b1; memRdata = 32'h1234_5678;
        tick(); tick();
        memAck = 1'b0;
        check_eq("idle ack respValid", 32'(respValid), 32'd0);
        check_eq("idle ack memReq",    32'(memReq), 32'd0);
        check_eq("idle ack readData",  readData, 32'd0);

        access("LB",  1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b1, 0, 32'h80FF_FF00,
               4'b1000, 32'h0, 32'hFFFF_FF80);
        access("LHU", 1'b0, 32'h0000_2002, 32'h0, 2'd1, 1'b0, 3, 32'hBEEF_1234,
               4'b1100, 32'h0, 32'h0000_BEEF);
        access("SB",  1'b1, 32'h0000_3001, 32'h1234_56AB, 2'd0, 1'b1, 1, 32'h0,
               4'b0010, 32'hABAB_ABAB, 32'h0000_BEEF);
        access("SH",  1'b1, 32'h0000_3002, 32'h1234_56AB, 2'd1, 1'b0, 0, 32'h0,
               4'b1100, 32'h56AB_56AB, 32'h0000_BEEF);
        access("LH",  1'b0, 32'h0000_3000, 32'h0, 2'd1, 1'b1, 0, 32'h1111_9234,
               4'b0011, 32'h0, 32'hFFFF_9234);
        access("LBU", 1'b0, 32'hFFFF_FFFD, 32'h0, 2'd0, 1'b0, 0, 32'h00C3_0000,
               4'b0010, 32'h0, 32'h0000_0000);
        access("LBU2", 1'b0, 32'hFFFF_FFFE, 32'h0, 2'd0, 1'b0, 0, 32'h00C3_0000,
               4'b0100, 32'h0, 32'h0000_00C3);

        // Back-to-back store then load of the same word
        access("SW",  1'b1, 32'h0000_5000, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 32'h0,
               4'hF, 32'hCAFE_F00D, 32'h0000_00C3);
        access("LW",  1'b0, 32'h0000_5000, 32'h0, 2'd2, 1'b0, 0, 32'hCAFE_F00D,
               4'hF, 32'h0, 32'hCAFE_F00D);

        // Reset abandons an outstanding bus request
        wait_ready("RST");
        reqValid = 1'b1; reqWrite = 1'b0; address = 32'h0000_7004; len = 2'd2; signExtend = 1'b0;
        tick();
        reqValid = 1'b0;
        check_eq("RST memReq before", 32'(memReq), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("RST memReq async", 32'(memReq), 32'd0);
        check_eq("RST respValid",    32'(respValid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("RST reqReady",   32'(reqReady), 32'd1);
        check_eq("RST respValid2", 32'(respValid), 32'd0);
        check_eq("RST readData",   readData, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        wait_ready("TRAP");
        reqValid = 1'b1; reqWrite = 1'b0; address = 32'h0000_4002; len = 2'd2; signExtend = 1'b0;
        memRdata = 32'h1234_5678;
        tick();
        reqValid = 1'b0;
        check_eq("TRAP memReq",    32'(memReq), 32'd0);
        check_eq("TRAP respValid", 32'(respValid), 32'd1);
        check_eq("TRAP respError", 32'(respError), 32'd1);
        check_eq("TRAP readData",  readData, 32'd0);
        tick();
        check_eq("TRAP pulse",     32'(respValid), 32'd0);
        check_eq("TRAP reqReady",  32'(reqReady), 32'd1);
        check_eq("TRAP memReq2",   32'(memReq), 32'd0);
        access("TRAP LB ok", 1'b0, 32'h0000_4003, 32'h0, 2'd0, 1'b1, 0, 32'h7F00_0000,
               4'b1000, 32'h0, 32'h0000_007F);
`else
        access("LW mis", 1'b0, 32'h0000_4002, 32'h0, 2'd2, 1'b0, 0, 32'h1234_5678,
               4'hF, 32'h0, 32'h1234_5678);
        access("LH mis", 1'b0, 32'h0000_6003, 32'h0, 2'd1, 1'b1, 1, 32'h8001_1234,
               4'b1100, 32'h0, 32'hFFFF_8001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
